// File: rtl/sram_timer.sv
// Memory-mapped 64-bit mtime/mtimecmp timer slave with a 1-cycle registered read and byte-lane writes.
// Optional MSIP software interrupt register at offset 3 when TIMER_SOFT_IRQ_EN is defined.
module sram_timer #(
    parameter int unsigned LEN_ADDR   = 64,
    parameter int unsigned PRESCALE   = 100,
    parameter int unsigned DEFAULT_EN = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [LEN_ADDR-1:0] addra,
    input  logic [63:0]         dina,
    output logic [63:0]         douta,
    input  logic                ena,
    input  logic [7:0]          wea,
    output logic                timer_irq
`ifdef TIMER_SOFT_IRQ_EN
    ,
    output logic                soft_irq
`endif
);

    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);
    localparam logic        EN_RESET     = 1'(DEFAULT_EN);

    logic [1:0]  sel;
    logic        wr;
    logic        wr_mtime;
    logic        wr_mtimecmp;
    logic        wr_ctrl;

    logic [15:0] prescale_q, prescale_d;
    logic        tick;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtime_inc;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        en_q, en_d;
    logic [63:0] douta_q, rdata;
    logic        irq_q;

    logic        unused_addr;
    assign unused_addr = ^{addra[LEN_ADDR-1:5], addra[2:0]};

    assign sel         = addra[4:3];
    assign wr          = ena & (|wea);
    assign wr_mtime    = wr & (sel == 2'd0);
    assign wr_mtimecmp = wr & (sel == 2'd1);
    assign wr_ctrl     = wr & (sel == 2'd2);

    assign tick = en_q & (prescale_q == PRESCALE_MAX);

    always_comb begin
        prescale_d = prescale_q;
        if (wr_ctrl) begin
            prescale_d = 16'd0;
        end else if (en_q) begin
            prescale_d = tick ? 16'd0 : prescale_q + 16'd1;
        end
    end

    // Written lanes take dina; others take the incremented value, so no carry crosses into them.
    assign mtime_inc = mtime_q + 64'(tick);

    always_comb begin
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        for (int i = 0; i < 8; i++) begin
            if (wr_mtime && wea[i]) begin
                mtime_d[8*i +: 8] = dina[8*i +: 8];
            end
            if (wr_mtimecmp && wea[i]) begin
                mtimecmp_d[8*i +: 8] = dina[8*i +: 8];
            end
        end
    end

    assign en_d = (wr_ctrl && wea[0]) ? dina[0] : en_q;

`ifdef TIMER_SOFT_IRQ_EN
    logic msip_q, msip_d;
    assign msip_d = (wr && (sel == 2'd3) && wea[0]) ? dina[0] : msip_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            msip_q <= 1'b0;
        end else begin
            msip_q <= msip_d;
        end
    end

    assign soft_irq = msip_q;
`endif

    always_comb begin
        rdata = 64'd0;
        case (sel)
            2'd0:    rdata = mtime_q;
            2'd1:    rdata = mtimecmp_q;
            2'd2:    rdata = {63'd0, en_q};
`ifdef TIMER_SOFT_IRQ_EN
            default: rdata = {63'd0, msip_q};
`else
            default: rdata = 64'd0;
`endif
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescale_q <= 16'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            en_q       <= EN_RESET;
            douta_q    <= 64'd0;
            irq_q      <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            if (ena) begin
                douta_q <= rdata;
            end
            // Compare of the current register values: irq trails any register change by one cycle.
            irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign douta     = douta_q;
    assign timer_irq = irq_q;

endmodule

// File: tb/tb_sram_timer.sv
// Randomized bench for sram_timer: two instances (PRESCALE=4 and PRESCALE=1) share one bus and are
// checked every cycle against a behavioural register-level model, plus directed literal checks.
module tb_sram_timer;

    logic        clk;
    logic        resetn;
    logic [63:0] addra;
    logic [63:0] dina;
    logic        ena;
    logic [7:0]  wea;
    logic [63:0] douta4, douta1;
    logic        irq4, irq1;
`ifdef TIMER_SOFT_IRQ_EN
    logic        sirq4, sirq1;
`endif

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    sram_timer #(.LEN_ADDR(64), .PRESCALE(4), .DEFAULT_EN(1)) dut4 (
        .clk       (clk),
        .resetn    (resetn),
        .addra     (addra),
        .dina      (dina),
        .douta     (douta4),
        .ena       (ena),
        .wea       (wea),
        .timer_irq (irq4)
`ifdef TIMER_SOFT_IRQ_EN
        ,
        .soft_irq  (sirq4)
`endif
    );

    sram_timer #(.LEN_ADDR(64), .PRESCALE(1), .DEFAULT_EN(1)) dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .addra     (addra),
        .dina      (dina),
        .douta     (douta1),
        .ena       (ena),
        .wea       (wea),
        .timer_irq (irq1)
`ifdef TIMER_SOFT_IRQ_EN
        ,
        .soft_irq  (sirq1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model, index 0 = PRESCALE 4, index 1 = PRESCALE 1.
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic [63:0] m_dout  [2];
    logic        m_en    [2];
    logic        m_irq   [2];
    logic        m_msip  [2];
    int unsigned m_cnt   [2];

    function automatic int unsigned ps(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mtime[k] = 64'd0;
            m_cmp[k]   = '1;
            m_dout[k]  = 64'd0;
            m_en[k]    = 1'b1;
            m_irq[k]   = 1'b0;
            m_msip[k]  = 1'b0;
            m_cnt[k]   = 0;
        end
    endtask

    task automatic model_step();
        int          sel;
        bit          wr;
        bit          tick;
        logic [63:0] inc, nm, nc;
        if (!resetn) begin
            model_reset();
            return;
        end
        sel = int'(addra[4:3]);
        wr  = ena && (wea != 8'd0);
        for (int k = 0; k < 2; k++) begin
            if (ena) begin
                case (sel)
                    0: m_dout[k] = m_mtime[k];
                    1: m_dout[k] = m_cmp[k];
                    2: m_dout[k] = {63'd0, m_en[k]};
`ifdef TIMER_SOFT_IRQ_EN
                    default: m_dout[k] = {63'd0, m_msip[k]};
`else
                    default: m_dout[k] = 64'd0;
`endif
                endcase
            end
            tick = 1'b0;
            if (m_en[k]) begin
                m_cnt[k] = (m_cnt[k] + 1) % ps(k);
                tick = (m_cnt[k] == 0);
            end
            if (wr && sel == 2) m_cnt[k] = 0;
            m_irq[k] = (m_mtime[k] >= m_cmp[k]);
            inc = m_mtime[k] + (tick ? 64'd1 : 64'd0);
            nm  = inc;
            nc  = m_cmp[k];
            for (int i = 0; i < 8; i++) begin
                if (wr && sel == 0 && wea[i]) nm[8*i +: 8] = dina[8*i +: 8];
                if (wr && sel == 1 && wea[i]) nc[8*i +: 8] = dina[8*i +: 8];
            end
            m_mtime[k] = nm;
            m_cmp[k]   = nc;
            if (wr && sel == 2 && wea[0]) m_en[k] = dina[0];
`ifdef TIMER_SOFT_IRQ_EN
            if (wr && sel == 3 && wea[0]) m_msip[k] = dina[0];
`endif
        end
    endtask

    // Drive one bus cycle at the negedge, advance the model on the posedge, return at the next negedge.
    task automatic cyc(input logic e, input logic [63:0] a, input logic [63:0] d, input logic [7:0] w);
        ena   = e;
        addra = a;
        dina  = d;
        wea   = w;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 64'd0, 8'd0);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        model_reset();
        idle(n);
        resetn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (resetn && chk_on) begin
            check("douta_p4", douta4, m_dout[0]);
            check("douta_p1", douta1, m_dout[1]);
            check("irq_p4", {63'd0, irq4}, {63'd0, m_irq[0]});
            check("irq_p1", {63'd0, irq1}, {63'd0, m_irq[1]});
`ifdef TIMER_SOFT_IRQ_EN
            check("soft_irq_p4", {63'd0, sirq4}, {63'd0, m_msip[0]});
            check("soft_irq_p1", {63'd0, sirq1}, {63'd0, m_msip[1]});
`endif
        end
    end

    initial begin
        logic [63:0] a, d;
        logic [7:0]  w;
        ena    = 1'b0;
        addra  = 64'd0;
        dina   = 64'd0;
        wea    = 8'd0;
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(3);
        chk_on = 1'b1;

        // Reset values.
        cyc(1'b1, 64'h0, 64'd0, 8'd0);
        check("rst_mtime_p4", douta4, 64'd0);
        check("rst_mtime_p1", douta1, 64'd0);
        cyc(1'b1, 64'h8, 64'd0, 8'd0);
        check("rst_cmp", douta4, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1'b1, 64'h10, 64'd0, 8'd0);
        check("rst_ctrl", douta1, 64'd1);
        check("rst_irq", {63'd0, irq1}, 64'd0);

        // Prescaled counting and hold while disabled.
        do_reset(2);
        idle(40);
        cyc(1'b1, 64'h0, 64'd0, 8'd0);
        check("count40_p4", douta4, 64'd10);
        check("count40_p1", douta1, 64'd40);
        cyc(1'b1, 64'h10, 64'd0, 8'h01);
        idle(20);
        cyc(1'b1, 64'h0, 64'd0, 8'd0);
        check("hold_p4", douta4, 64'd10);
        check("hold_p1", douta1, 64'd42);

        // Byte-lane write.
        cyc(1'b1, 64'h0, 64'h1122_3344_5566_7788, 8'hFF);
        cyc(1'b1, 64'h0, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
        cyc(1'b1, 64'h0, 64'd0, 8'd0);
        check("lanes_p4", douta4, 64'h1122_3344_BBBB_BBBB);
        check("lanes_p1", douta1, 64'h1122_3344_BBBB_BBBB);

        // Interrupt timing on the every-cycle instance.
        cyc(1'b1, 64'h0, 64'd0, 8'hFF);
        cyc(1'b1, 64'h8, 64'd5, 8'hFF);
        cyc(1'b1, 64'h10, 64'd1, 8'h01);
        idle(5);
        check("irq_before", {63'd0, irq1}, 64'd0);
        idle(1);
        check("irq_rise", {63'd0, irq1}, 64'd1);
        cyc(1'b1, 64'h8, 64'd100, 8'hFF);
        idle(1);
        check("irq_fall", {63'd0, irq1}, 64'd0);

        // Wrap and tick/write collision.
        cyc(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        idle(1);
        cyc(1'b1, 64'h0, 64'd0, 8'd0);
        check("wrap_p1", douta1, 64'd0);
        cyc(1'b1, 64'h0, 64'h1FF, 8'hFF);
        cyc(1'b1, 64'h0, 64'h0, 8'h01);
        cyc(1'b1, 64'h0, 64'd0, 8'd0);
        check("collide_p1", douta1, 64'h200);

`ifdef TIMER_SOFT_IRQ_EN
        cyc(1'b1, 64'h18, 64'd1, 8'h01);
        check("msip_set", {63'd0, sirq1}, 64'd1);
`endif

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            a = {$urandom, $urandom};
            d = {$urandom, $urandom};
            w = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
            if (a[4:3] == 2'd1 && $urandom_range(0, 1) == 1)
                d = m_mtime[1] + 64'($urandom_range(0, 8));
            if (a[4:3] == 2'd0 && $urandom_range(0, 3) == 0)
                d = m_cmp[0] - 64'($urandom_range(0, 3));
            if (a[4:3] == 2'd2 && $urandom_range(0, 3) != 0)
                d[0] = 1'b1;
            cyc(1'($urandom_range(0, 1)), a, d, w);
        end

        // Asynchronous reset between edges.
        cyc(1'b1, 64'h8, 64'd0, 8'hFF);
        cyc(1'b1, 64'h0, 64'h55, 8'hFF);
        idle(2);
        cyc(1'b1, 64'h0, 64'd0, 8'd0);
`ifdef TIMER_SOFT_IRQ_EN
        cyc(1'b1, 64'h18, 64'd1, 8'h01);
`endif
        check("pre_rst_irq", {63'd0, irq1}, 64'd1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("arst_douta_p4", douta4, 64'd0);
        check("arst_douta_p1", douta1, 64'd0);
        check("arst_irq_p4", {63'd0, irq4}, 64'd0);
        check("arst_irq_p1", {63'd0, irq1}, 64'd0);
`ifdef TIMER_SOFT_IRQ_EN
        check("arst_soft_irq", {63'd0, sirq1}, 64'd0);
`endif
        #1;
        resetn = 1'b1;
        cyc(1'b1, 64'h0, 64'd0, 8'd0);
        check("arst_mtime_p4", douta4, 64'd0);
        check("arst_mtime_p1", douta1, 64'd0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_timer.md
Name: sram_timer

Overview:
- Memory-mapped 64-bit machine timer (mtime/mtimecmp) on the SoC's simple SRAM-style device bus.
- Sits downstream of the device-side crossbar as one more slave, next to the UART and board-IO slaves; responds to data-port loads and stores from the pipeline.
- Produces a level timer interrupt for the core.
- Behaves like the sram slaves: registered 1-cycle read, 8-bit byte-enable writes.

Parameters:
- LEN_ADDR, 64, width of addra.
- PRESCALE, 100, clk cycles per mtime tick; legal range 1..65535; 1 = tick every cycle.
- DEFAULT_EN, 1, reset value of CTRL.EN.

Ports:
- clk  input  1  single clock for all logic.
- resetn  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronous to clk.
- addra  input  LEN_ADDR  byte address; only addra[4:3] decoded (64-bit word select), other bits ignored.
- dina  input  64  write data.
- douta  output  64  read data, valid the cycle after an ena cycle.
- ena  input  1  access strobe.
- wea  input  8  byte write enables; wea[i] covers dina[8i+7:8i]; all zero = read.
- timer_irq  output  1  level interrupt, high while mtime >= mtimecmp (unsigned).

Behaviour:
- Register map by addra[4:3]:
  - 0 MTIME (rw).
  - 1 MTIMECMP (rw).
  - 2 CTRL: bit0 EN, other bits read 0 and ignore writes.
  - 3 reserved: reads 0, writes ignored.
- Reset values: MTIME=0; MTIMECMP=64'hFFFF_FFFF_FFFF_FFFF; CTRL.EN=DEFAULT_EN; prescaler count=0; douta=0; timer_irq=0.
- Prescaler:
  - 16-bit counter, active only when EN=1.
  - Counts 0..PRESCALE-1; on reaching PRESCALE-1 it wraps to 0 and asserts an internal tick for that cycle.
  - With EN=0 the counter holds its value.
- MTIME increments by 1 on each tick, wrapping from all-ones to 0 with no flag.
- Write: ena=1 and wea!=0 updates the selected register on that rising edge, byte lanes independent.
- Simultaneous tick and MTIME write in the same cycle:
  - Written bytes take dina.
  - Unwritten bytes take the incremented value's bytes; no carry propagates into written bytes.
- A write to CTRL clears the prescaler counter to 0.
- Read:
  - On ena=1 and wea=0, douta <= selected register value as of the start of that cycle (pre-update).
  - douta holds its value when ena=0.
  - On a write cycle douta also updates with the pre-write value; software ignores it.
- timer_irq:
  - Registered compare; updates the cycle after MTIME or MTIMECMP changes, so latency is 1 cycle from register change.
  - Deasserts the cycle after MTIMECMP is written above MTIME.
- resetn asserted mid-operation: all state returns to reset values immediately; any in-flight read data is lost.

Optional Feature:
- Macro: TIMER_SOFT_IRQ_EN.
- Defined:
  - Offset 3 becomes MSIP: bit0 rw, reset 0, other bits read 0.
  - Extra output port soft_irq (output, 1 bit) = MSIP bit0, registered.
  - A byte write with wea[0]=1 updates MSIP bit0.
- Not defined: offset 3 is reserved as above and the soft_irq port does not exist.

Test Plan:
- Reset values: assert resetn=0 for 3 cycles, release, read offsets 0x0/0x8/0x10 → douta 0 / 64'hFFFF_FFFF_FFFF_FFFF / 1 on the cycle after each ena; timer_irq=0.
- Prescaled counting: PRESCALE=4, EN=1, run 40 cycles after reset, read MTIME → 10 (±1 by sample point; check exact edge count); EN=0 via CTRL write, wait 20 cycles → MTIME unchanged.
- Interrupt timing: write MTIMECMP=5, PRESCALE=1 → timer_irq rises exactly 1 cycle after MTIME becomes 5; write MTIMECMP=100 → timer_irq low the next cycle.
- Byte-lane write: MTIME=64'h1122_3344_5566_7788, EN=0, write wea=8'h0F with dina=64'hAAAA_AAAA_BBBB_BBBB → read 64'h1122_3344_BBBB_BBBB.
- Wrap and collision: EN=1, PRESCALE=1, write MTIME=64'hFFFF_FFFF_FFFF_FFFF → next tick MTIME=0; write wea=8'h01 dina=8'h00 on a tick cycle with MTIME=64'h1FF → result 64'h200 with low byte forced 0, i.e. 64'h200.
- Async reset mid-count plus option: with TIMER_SOFT_IRQ_EN, write MSIP=1 → soft_irq=1 next cycle; pulse resetn low between clock edges → soft_irq, timer_irq, MTIME and douta clear immediately without a clock edge.
